// File: rtl/top_multi_if.sv
// Display/control bundle of the counter lab top: the synchronous clear going
// in, the registered count and its seven-segment glyph coming out.
interface top_multi_if;
  logic       reset2;
  logic [3:0] salida;
  logic [6:0] sevenSeg;

  // Board/bench side: drives the clear, observes the display.
  modport master (output reset2, input salida, input sevenSeg);
  // Counter block side.
  modport slave  (input reset2, output salida, output sevenSeg);
endinterface

// File: rtl/top_multi.sv
// Counter/display lab top: divides clk_in into a one-cycle tick every DIV
// cycles, counts ticks on a 4-bit wrapping counter, and shows the count on
// salida and on one active-low seven-segment digit.
// Optional build macro TOP_MULTI_BCD_EN: decimal counter (9 -> 0) with the
// A-F glyphs blanked; undefined gives the full hex counter.
module top_multi #(
  parameter int DIV = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  top_multi_if.slave  bus
);

  // A divider of DIV=1 still needs one bit so the vector stays legal.
  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
`ifdef TOP_MULTI_BCD_EN
  localparam logic [3:0]       CNT_LAST = 4'd9;
`else
  localparam logic [3:0]       CNT_LAST = 4'd15;
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             tick;
  logic [6:0]       seg;

  assign tick = (div_q == DIV_LAST);

  // Next-state for divider and counter; reset2 overrides the tick.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned, which would infer a latch.
    div_d = tick ? '0 : div_q + 1'b1;
    cnt_d = cnt_q;
    if (tick) cnt_d = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
    if (bus.reset2) begin
      div_d = '0;
      cnt_d = 4'd0;
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk_in or posedge reset) begin
    // NOTE: non-blocking assignments here so all flops sample pre-edge values together.
    if (reset) begin
      div_q <= '0;
      cnt_q <= 4'd0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  // Active-low hex glyph decode of the registered count, {g..a}.
  always_comb begin
    seg = 7'h7F;
    case (cnt_q)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
`ifndef TOP_MULTI_BCD_EN
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
`endif
      default: seg = 7'h7F;
    endcase
  end

  assign bus.salida   = cnt_q;
  assign bus.sevenSeg = seg;

endmodule

// File: tb/tb_top_multi.sv
// Directed bench for top_multi with DIV=4 and a 10 ns clk_in.
module tb_top_multi;

  localparam int DIV = 4;
`ifdef TOP_MULTI_BCD_EN
  localparam int MOD = 10;
`else
  localparam int MOD = 16;
`endif

  logic clk_in = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  top_multi_if bus_if ();

  top_multi #(.DIV(DIV)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus_if.slave)
  );

  always #5 clk_in = ~clk_in;

  // Hand-written glyph table, active-low {g..a}.
  function automatic logic [6:0] exp_seg(input int v);
    case (v)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;
`ifndef TOP_MULTI_BCD_EN
      10: return 7'h08;  11: return 7'h03;  12: return 7'h46;  13: return 7'h21;
      14: return 7'h06;  15: return 7'h0E;
`endif
      default: return 7'h7F;
    endcase
  endfunction

  // One rising edge, then settle at the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.reset2 = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus_if.salida !== 4'd0 || bus_if.sevenSeg !== 7'h40) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d: salida=%h seg=%h, want 0/40", i, bus_if.salida, bus_if.sevenSeg);
      end
      step();
    end
    // Async reset released, reset2 still held: counter stays frozen.
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (bus_if.salida !== 4'd0 || bus_if.sevenSeg !== 7'h40) begin
        fails++;
        $display("FAIL reset2_hold cyc=%0d: salida=%h seg=%h, want 0/40", i, bus_if.salida, bus_if.sevenSeg);
      end
    end
    bus_if.reset2 = 1'b0;
  endtask

  // Runs edges from a cleared state; count after n edges is (n/DIV) mod MOD.
  task automatic run_and_check(input string name, input int first, input int last);
    int exp_cnt;
    for (int n = first; n <= last; n++) begin
      step();
      exp_cnt = (n / DIV) % MOD;
      checks++;
      if (bus_if.salida !== 4'(exp_cnt) || bus_if.sevenSeg !== exp_seg(exp_cnt)) begin
        fails++;
        $display("FAIL %s edge=%0d: salida=%h seg=%h, want %h/%h", name, n,
                 bus_if.salida, bus_if.sevenSeg, 4'(exp_cnt), exp_seg(exp_cnt));
      end
    end
  endtask

  task automatic test_count();
    run_and_check("count", 1, 40);
    // Edge 40: hex shows 10 ("A", 08); decimal build has wrapped to 0.
    checks++;
    if (bus_if.salida !== 4'(40 / DIV % MOD)) begin
      fails++;
      $display("FAIL count_40: salida=%h, want %h", bus_if.salida, 4'(40 / DIV % MOD));
    end
  endtask

  task automatic test_wrap();
    int max_seen = 0;
    for (int n = 41; n <= 104; n++) begin
      step();
      if (int'(bus_if.salida) > max_seen) max_seen = int'(bus_if.salida);
      checks++;
      if (bus_if.salida !== 4'((n / DIV) % MOD) || bus_if.sevenSeg !== exp_seg((n / DIV) % MOD)) begin
        fails++;
        $display("FAIL wrap edge=%0d: salida=%h seg=%h, want %h/%h", n, bus_if.salida,
                 bus_if.sevenSeg, 4'((n / DIV) % MOD), exp_seg((n / DIV) % MOD));
      end
    end
    checks++;
    if (max_seen !== MOD - 1) begin
      fails++;
      $display("FAIL wrap_max: max salida=%0d, want %0d", max_seen, MOD - 1);
    end
  endtask

  task automatic test_sync_clear();
    reset = 1'b1;
    #1 reset = 1'b0;
    // 22 edges: count 5, divider mid-way at 2.
    run_and_check("pre_clear", 1, 22);
    checks++;
    if (bus_if.salida !== 4'd5 || bus_if.sevenSeg !== 7'h12) begin
      fails++;
      $display("FAIL pre_clear5: salida=%h seg=%h, want 5/12", bus_if.salida, bus_if.sevenSeg);
    end
    bus_if.reset2 = 1'b1;
    step();
    bus_if.reset2 = 1'b0;
    checks++;
    if (bus_if.salida !== 4'd0 || bus_if.sevenSeg !== 7'h40) begin
      fails++;
      $display("FAIL sync_clear: salida=%h seg=%h, want 0/40", bus_if.salida, bus_if.sevenSeg);
    end
    // Divider restarted: edges 1..3 keep 0, edge 4 gives 1.
    run_and_check("post_clear", 1, 8);
  endtask

  task automatic test_async_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    run_and_check("pre_async", 1, 28);
    checks++;
    if (bus_if.salida !== 4'd7 || bus_if.sevenSeg !== 7'h78) begin
      fails++;
      $display("FAIL pre_async7: salida=%h seg=%h, want 7/78", bus_if.salida, bus_if.sevenSeg);
    end
    // Assert between edges; outputs must clear before the next rising edge.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus_if.salida !== 4'd0 || bus_if.sevenSeg !== 7'h40) begin
      fails++;
      $display("FAIL async_reset: salida=%h seg=%h, want 0/40", bus_if.salida, bus_if.sevenSeg);
    end
    step();
    checks++;
    if (bus_if.salida !== 4'd0) begin
      fails++;
      $display("FAIL async_hold: salida=%h, want 0", bus_if.salida);
    end
    reset = 1'b0;
    run_and_check("post_async", 1, 12);
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_sync_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/top_multi.md
Name: top_multi

Overview:
- Top-level demo block: divides `clk_in` into a periodic tick and counts ticks with a 4-bit wrap-around counter.
- Presents the count on `salida` and on a single active-low seven-segment digit (`sevenSeg`, hex glyphs).
- Board-level top for the counter/display lab; no upstream handshake.

Parameters:
- DIV, 4, clk_in cycles per count tick. Legal range ≥ 1; DIV=1 means a tick every cycle. Divider width = $clog2(DIV) with a minimum of 1.

Ports:
- clk_in  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset of all state.
- reset2  input  1  synchronous active-high clear of the counter and divider; sampled on the rising clk_in edge.
- sevenSeg  output  7  active-low segments, bit0=a … bit6=g; 0 = segment lit.
- salida  output  4  current count value, unsigned.

Behaviour:
- One clock, clk_in. Reset is asynchronous and active-high on `reset`. All flops clear immediately on reset assertion, independent of clk_in.
- Reset values:
  - divider = 0, count = 0.
  - salida = 4'h0, sevenSeg = 7'h40 (glyph "0").
- Divider:
  - Counts 0..DIV-1, then wraps to 0.
  - tick = 1 for exactly one clk_in cycle, when divider == DIV-1.
- Counter:
  - On a rising edge with tick=1: count <= count+1, modulo 16 (15 -> 0 wrap, no saturation).
  - No change when tick=0.
- reset2:
  - If 1 at a rising edge: divider <= 0 and count <= 0; this overrides tick.
  - Holding reset2 high freezes the counter at 0.
- Priority: reset (async) > reset2 > tick.
- After reset and reset2 both release, the first increment occurs on the DIV-th rising edge. Example, DIV=4: edges 1, 2, 3 advance the divider; edge 4 makes count = 1.
- Timing per increment:
  - salida = count, registered; it changes only on a clock edge or on reset.
  - sevenSeg = combinational decode of count; it updates in the same cycle as salida.
- Decode table, active-low hex, {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset asserted mid-count: outputs return to 0 / 40 immediately; counting resumes from 0 after release.
- No X on any output after reset; the decoder has a default arm that outputs 7'h7F (blank).

Optional Feature:
- Macro: TOP_MULTI_BCD_EN.
- Defined:
  - Counter is decimal: wraps 9 -> 0.
  - salida stays within 0..9.
  - Decoder codes A–F output 7'h7F (blank); they are unreachable in normal operation.
- Undefined: hex behaviour as specified above (wrap 15 -> 0, full hex glyphs).

Test Plan:
- reset=1, reset2=1 for 200 ns (clk 10 ns, DIV=4) -> salida=0 and sevenSeg=7'h40 throughout; no increments.
- Release both, run 40 edges -> salida advances 1 per 4 edges, reaching 10 (7'h08, "A") after 40 edges; sevenSeg matches the table at every step.
- Run 64 edges past 15 -> 15 (7'h0E) is followed by 0 (7'h40): modulo-16 wrap with no glitch cycle.
- Count at 5; pulse reset2 for 1 cycle -> next edge count=0 and the divider restarts; the next increment comes 4 edges after release.
- Assert reset asynchronously between clock edges while count=7 -> outputs become 0 / 7'h40 before the next clk_in edge.
- With TOP_MULTI_BCD_EN defined: run 40 edges -> sequence 0..9, then 0; after 9 (7'h10), salida never exceeds 9.
